muldiv_sequencer: RTL and testbench

//  Multi-cycle multiply/divide engine and its sequencer, attached to the Execute stage of the pipelined core.

---
 rtl/core_pkg.sv | 27 ++
 rtl/muldiv_sequencer_if.sv | 29 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_sequencer.sv | 130 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the multiply/divide engine: op codes, sequencer states
// and small op-classification helpers.
package core_pkg;

  typedef enum logic [1:0] {
    MD_UMULL = 2'b00,
    MD_SMULL = 2'b01,
    MD_UDIV  = 2'b10,
    MD_SDIV  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX,
    MD_DONE
  } md_state_t;

  function automatic logic op_is_div(input md_op_t op);
    return (op == MD_UDIV) || (op == MD_SDIV);
  endfunction

  function automatic logic op_is_signed(input md_op_t op);
    return (op == MD_SMULL) || (op == MD_SDIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> mul/div engine handshake: op request, flush, stall and result.
interface muldiv_sequencer_if
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             StartE;
  md_op_t           OpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             AbortE;
  logic             MulDivStall;
  logic             DoneE;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic             DivZero;

  modport master (
    output StartE, OpE, SrcAE, SrcBE, AbortE,
    input  MulDivStall, DoneE, ResultLo, ResultHi, DivZero
  );

  modport slave (
    input  StartE, OpE, SrcAE, SrcBE, AbortE,
    output MulDivStall, DoneE, ResultLo, ResultHi, DivZero
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply (acc = {hi, multiplier}),
// restoring shift-subtract for divide (acc = {remainder, dividend/quotient}).
module muldiv_step
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_t             op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  assign hi    = acc[2*WIDTH-1:WIDTH];
  assign lo    = acc[WIDTH-1:0];
  assign sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
  assign trial = {hi, lo[WIDTH-1]};
  // trial < 2*divisor, so the W+1-bit difference sign bit is exact
  assign diff  = trial - {1'b0, operand};

  always_comb begin
    acc_next = '0;
    q_bit    = 1'b0;
    if (op_is_div(op)) begin
      q_bit    = ~diff[WIDTH];
      // quotient bit is left as 0 here and merged by the sequencer from q_bit
      acc_next = {(q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), lo[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV sequencer for the Execute stage: stalls the pipe while
// iterating on operand magnitudes, applies signed fix-up, then pulses DoneE.
module muldiv_sequencer
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  muldiv_sequencer_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  md_state_t          state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  md_op_t             op_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic [WIDTH-1:0]   operand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   result_lo_reg;
  logic [WIDTH-1:0]   result_hi_reg;
  logic               done_reg;
  logic               div_zero_reg;

  logic               in_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic [WIDTH-1:0]   fix_lo;
  logic [WIDTH-1:0]   fix_hi;

  assign in_signed = op_is_signed(bus.OpE);
  assign abs_a     = (in_signed && bus.SrcAE[WIDTH-1]) ? -bus.SrcAE : bus.SrcAE;
  assign abs_b     = (in_signed && bus.SrcBE[WIDTH-1]) ? -bus.SrcBE : bus.SrcBE;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_reg),
    .acc      (acc_reg),
    .operand  (operand_reg),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Unsigned ops latch both sign flags as 0, so the fix-up is a pass-through
  always_comb begin
    fix_lo = acc_reg[WIDTH-1:0];
    fix_hi = acc_reg[2*WIDTH-1:WIDTH];
    if (op_is_div(op_reg)) begin
      if (sign_a_reg ^ sign_b_reg) fix_lo = -acc_reg[WIDTH-1:0];
      if (sign_a_reg)              fix_hi = -acc_reg[2*WIDTH-1:WIDTH];
    end else if (sign_a_reg ^ sign_b_reg) begin
      {fix_hi, fix_lo} = -acc_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= MD_IDLE;
      cnt_reg       <= '0;
      op_reg        <= MD_UMULL;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      operand_reg   <= '0;
      acc_reg       <= '0;
      result_lo_reg <= '0;
      result_hi_reg <= '0;
      done_reg      <= 1'b0;
      div_zero_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        MD_IDLE: begin
          if (bus.StartE && !bus.AbortE) begin
            op_reg     <= bus.OpE;
            sign_a_reg <= in_signed & bus.SrcAE[WIDTH-1];
            sign_b_reg <= in_signed & bus.SrcBE[WIDTH-1];
            cnt_reg    <= '0;
            if (op_is_div(bus.OpE) && (bus.SrcBE == '0)) begin
              result_lo_reg <= '0;
              result_hi_reg <= bus.SrcAE;
              div_zero_reg  <= 1'b1;
              done_reg      <= 1'b1;
              state_reg     <= MD_DONE;
            end else begin
              acc_reg     <= {{WIDTH{1'b0}}, (op_is_div(bus.OpE) ? abs_a : abs_b)};
              operand_reg <= op_is_div(bus.OpE) ? abs_b : abs_a;
              state_reg   <= MD_RUN;
            end
          end
        end
        MD_RUN: begin
          if (bus.AbortE) begin
            state_reg <= MD_IDLE;
          end else begin
            acc_reg <= {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_STEP) state_reg <= MD_FIX;
          end
        end
        MD_FIX: begin
          if (bus.AbortE) begin
            state_reg <= MD_IDLE;
          end else begin
            result_lo_reg <= fix_lo;
            result_hi_reg <= fix_hi;
            div_zero_reg  <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= MD_DONE;
          end
        end
        MD_DONE: state_reg <= MD_IDLE;
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

  // Combinational so the hazard unit freezes E in the very cycle the op is offered
  assign bus.MulDivStall = reset &&
                           ((state_reg == MD_IDLE && bus.StartE && !bus.AbortE) ||
                            (state_reg == MD_RUN) || (state_reg == MD_FIX));
  assign bus.DoneE    = done_reg;
  assign bus.ResultLo = result_lo_reg;
  assign bus.ResultHi = result_hi_reg;
  assign bus.DivZero  = div_zero_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: latency, stall window, signed
// fix-up, divide-by-zero, abort and mid-op reset.
module tb_muldiv_sequencer;
  import core_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input md_op_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_lo,
                        input logic [W-1:0] exp_hi, input logic exp_dz, input int exp_lat);
    int lat;
    int stall_cnt;
    @(negedge clk);
    bus.StartE = 1'b1;
    bus.OpE    = op;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    #1;
    stall_cnt = bus.MulDivStall ? 1 : 0;
    @(negedge clk);
    bus.StartE = 1'b0;
    lat = 1;
    while (!bus.DoneE && lat < 100) begin
      if (bus.MulDivStall) stall_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"},   64'(lat), 64'(exp_lat));
    check({tag, "_stall"}, 64'(stall_cnt), 64'(exp_lat));
    check({tag, "_stall_done"}, 64'(bus.MulDivStall), 64'd0);
    check({tag, "_lo"}, 64'(bus.ResultLo), 64'(exp_lo));
    check({tag, "_hi"}, 64'(bus.ResultHi), 64'(exp_hi));
    check({tag, "_dz"}, 64'(bus.DivZero), 64'(exp_dz));
    $display("op %-10s a=%08h b=%08h lo=%08h hi=%08h dz=%0d lat=%0d",
             tag, a, b, bus.ResultLo, bus.ResultHi, bus.DivZero, lat);
    @(negedge clk);
    check({tag, "_pulse"},   64'(bus.DoneE), 64'd0);
    check({tag, "_hold_lo"}, 64'(bus.ResultLo), 64'(exp_lo));
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.DoneE) seen++;
    end
    check({tag, "_no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    bus.StartE = 1'b0;
    bus.OpE    = MD_UMULL;
    bus.SrcAE  = '0;
    bus.SrcBE  = '0;
    bus.AbortE = 1'b0;

    #12;
    check("rst_stall", 64'(bus.MulDivStall), 64'd0);
    check("rst_done",  64'(bus.DoneE), 64'd0);
    check("rst_lo",    64'(bus.ResultLo), 64'd0);
    check("rst_hi",    64'(bus.ResultHi), 64'd0);
    check("rst_dz",    64'(bus.DivZero), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("umull_max", MD_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 34);
    run_op("smull_m2x3", MD_SMULL, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("smull_min2", MD_SMULL, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0, 34);
    run_op("sdiv_m7d2", MD_SDIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("sdiv_7dm2", MD_SDIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 34);
    run_op("udiv_100d7", MD_UDIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    run_op("udiv_5d0", MD_UDIV, 32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1);
    run_op("sdiv_m5d0", MD_SDIV, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'hFFFF_FFFB, 1'b1, 1);
    run_op("sdiv_ovf", MD_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 34);

    // Abort during RUN: results from sdiv_ovf must survive, no DoneE
    @(negedge clk);
    bus.StartE = 1'b1;
    bus.OpE    = MD_UMULL;
    bus.SrcAE  = 32'h0000_1234;
    bus.SrcBE  = 32'h0000_0010;
    @(negedge clk);
    bus.StartE = 1'b0;
    repeat (9) @(negedge clk);
    bus.AbortE = 1'b1;
    @(negedge clk);
    bus.AbortE = 1'b0;
    check("abort_stall", 64'(bus.MulDivStall), 64'd0);
    expect_no_done("abort_run", 40);
    check("abort_lo", 64'(bus.ResultLo), 64'h8000_0000);
    check("abort_hi", 64'(bus.ResultHi), 64'h0000_0000);
    $display("op abort_run at RUN cycle 10");

    // AbortE together with StartE in IDLE: op refused
    @(negedge clk);
    bus.StartE = 1'b1;
    bus.AbortE = 1'b1;
    bus.OpE    = MD_UMULL;
    bus.SrcAE  = 32'd2;
    bus.SrcBE  = 32'd2;
    #1;
    check("abort_idle_stall", 64'(bus.MulDivStall), 64'd0);
    @(negedge clk);
    bus.StartE = 1'b0;
    bus.AbortE = 1'b0;
    expect_no_done("abort_idle", 40);
    $display("op abort_idle refused");

    run_op("umull_3x4", MD_UMULL, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, 34);

    // Reset mid-op at RUN cycle 5
    @(negedge clk);
    bus.StartE = 1'b1;
    bus.OpE    = MD_UMULL;
    bus.SrcAE  = 32'h0000_FFFF;
    bus.SrcBE  = 32'h0000_FFFF;
    @(negedge clk);
    bus.StartE = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_stall", 64'(bus.MulDivStall), 64'd0);
    check("mid_rst_done",  64'(bus.DoneE), 64'd0);
    check("mid_rst_lo",    64'(bus.ResultLo), 64'd0);
    check("mid_rst_hi",    64'(bus.ResultHi), 64'd0);
    check("mid_rst_dz",    64'(bus.DivZero), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    expect_no_done("mid_rst", 40);
    $display("op mid_rst at RUN cycle 5");

    // StartE held high through RUN and DONE with different operands: ignored
    begin
      int lat;
      @(negedge clk);
      bus.StartE = 1'b1;
      bus.OpE    = MD_UMULL;
      bus.SrcAE  = 32'd3;
      bus.SrcBE  = 32'd4;
      @(negedge clk);
      bus.OpE    = MD_UDIV;
      bus.SrcAE  = 32'd9;
      bus.SrcBE  = 32'd0;
      lat = 1;
      while (!bus.DoneE && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check("held_lat", 64'(lat), 64'd34);
      check("held_lo",  64'(bus.ResultLo), 64'd12);
      check("held_hi",  64'(bus.ResultHi), 64'd0);
      check("held_dz",  64'(bus.DivZero), 64'd0);
      @(posedge clk);
      #1;
      bus.StartE = 1'b0;
      #1;
      check("held_idle_stall", 64'(bus.MulDivStall), 64'd0);
      expect_no_done("held", 40);
      check("held_keep_lo", 64'(bus.ResultLo), 64'd12);
      $display("op held_start lo=%08h lat=%0d", bus.ResultLo, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
